// File: rtl/pix_pll_reconfig_seq.sv
// rtl/pix_pll_reconfig_seq.sv - pixel PLL reconfig sequencer: counter writes, reconfig, areset, lock wait
// Defining PIX_PLL_C1_EN adds the c1_div input and a fourth counter (C1) after C0.
module pix_pll_reconfig_seq #(
  parameter int ARESET_CYCLES = 16,
  parameter int BUSY_TIMEOUT  = 1023,
  parameter int LOCK_TIMEOUT  = 65535
) (
  input  logic       hb_clk,
  input  logic       hb_rst,
  input  logic       start,
  input  logic [8:0] n_div,
  input  logic [8:0] m_div,
  input  logic [8:0] c0_div,
`ifdef PIX_PLL_C1_EN
  input  logic [8:0] c1_div,
`endif
  input  logic       busy,
  input  logic       pix_locked,
  output logic       write_param,
  output logic [3:0] counter_type,
  output logic [2:0] counter_param,
  output logic [8:0] data_in,
  output logic       reconfig,
  output logic       pll_areset_in,
  output logic       seq_busy,
  output logic       done,
  output logic [1:0] err
);

`ifdef PIX_PLL_C1_EN
  localparam logic [3:0] LAST_IDX = 4'd15;
`else
  localparam logic [3:0] LAST_IDX = 4'd11;
`endif
  localparam logic [15:0] BUSY_LIM   = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIM   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] ARESET_LIM = 16'(ARESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WAITB, S_RECONF, S_WAITR, S_ARESET, S_WAITL
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  div_q [4];
  logic [8:0]  div_d [4];
  logic [1:0]  err_q, err_d;
  logic        done_q, done_d;
  logic        lock_prev_q, lock_prev_d;
  logic [3:0]  ctype_q, ctype_d;
  logic [2:0]  cparam_q, cparam_d;
  logic [8:0]  data_q, data_d;

  // p: 0=high, 1=low, 2=bypass, 3=odd; a zero divide behaves as divide-by-one
  function automatic logic [8:0] param_value(input logic [8:0] d, input logic [1:0] p);
    logic [8:0] dd;
    logic [9:0] sum;
    dd  = (d == 9'd0) ? 9'd1 : d;
    sum = {1'b0, dd} + 10'd1;
    case (p)
      2'd0:    param_value = sum[9:1];
      2'd1:    param_value = {1'b0, dd[8:1]};
      2'd2:    param_value = {8'd0, (dd == 9'd1)};
      default: param_value = {8'd0, dd[0]};
    endcase
  endfunction

  always_ff @(posedge hb_clk or posedge hb_rst) begin
    if (hb_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      div_q       <= '{default: '0};
      err_q       <= '0;
      done_q      <= 1'b0;
      lock_prev_q <= 1'b0;
      ctype_q     <= '0;
      cparam_q    <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      err_q       <= err_d;
      done_q      <= done_d;
      lock_prev_q <= lock_prev_d;
      ctype_q     <= ctype_d;
      cparam_q    <= cparam_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    done_d  = 1'b0;
    div_d   = div_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WR;
          idx_d    = '0;
          err_d    = 2'b00;
          div_d[0] = n_div;
          div_d[1] = m_div;
          div_d[2] = c0_div;
`ifdef PIX_PLL_C1_EN
          div_d[3] = c1_div;
`endif
        end
      end
      S_WR: state_d = S_WAITB;
      S_WAITB: begin
        if (cnt_q >= 16'd2 && !busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_RECONF;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_WR;
          end
        end else if (cnt_q == BUSY_LIM) begin
          err_d   = 2'b01;
          state_d = S_IDLE;
        end
      end
      S_RECONF: state_d = S_WAITR;
      S_WAITR: begin
        if (cnt_q >= 16'd2 && !busy) begin
          state_d = S_ARESET;
        end else if (cnt_q == BUSY_LIM) begin
          err_d   = 2'b01;
          state_d = S_IDLE;
        end
      end
      S_ARESET: begin
        if (cnt_q == ARESET_LIM) state_d = S_WAITL;
      end
      S_WAITL: begin
        // lock qualification is checked first so it wins over a coincident timeout
        if (pix_locked && lock_prev_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == LOCK_LIM) begin
          err_d   = 2'b10;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = (state_d != state_q) ? 16'd0 :
                  (cnt_q == 16'hFFFF)  ? cnt_q : cnt_q + 16'd1;
    lock_prev_d = (state_d == S_WAITL && state_q == S_WAITL) ? pix_locked : 1'b0;
    ctype_d     = ctype_q;
    cparam_d    = cparam_q;
    data_d      = data_q;
    // index bits map onto the sparse encodings: counter {0,1,4,5}, param {0,1,4,5}
    if (state_d == S_WR) begin
      ctype_d  = {1'b0, idx_d[3], 1'b0, idx_d[2]};
      cparam_d = {idx_d[1], 1'b0, idx_d[0]};
      data_d   = param_value(div_d[idx_d[3:2]], idx_d[1:0]);
    end
  end

  always_comb begin
    write_param   = (state_q == S_WR);
    reconfig      = (state_q == S_RECONF);
    pll_areset_in = (state_q == S_ARESET);
    seq_busy      = (state_q != S_IDLE);
    done          = done_q;
    err           = err_q;
    counter_type  = ctype_q;
    counter_param = cparam_q;
    data_in       = data_q;
  end

endmodule

// File: tb/tb_pix_pll_reconfig_seq.sv
// tb/tb_pix_pll_reconfig_seq.sv - self-checking bench for pix_pll_reconfig_seq
module tb_pix_pll_reconfig_seq;
  localparam int AR = 16;
  localparam int BT = 1023;
  localparam int LT = 300;
`ifdef PIX_PLL_C1_EN
  localparam int NCNT = 4;
`else
  localparam int NCNT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] n_div = '0, m_div = '0, c0_div = '0, c1_div = '0;
  logic       busy = 1'b0;
  logic       pix_locked = 1'b0;
  logic       write_param, reconfig, pll_areset_in, seq_busy, done;
  logic [3:0] counter_type;
  logic [2:0] counter_param;
  logic [8:0] data_in;
  logic [1:0] err;

  always #5 clk = ~clk;

  pix_pll_reconfig_seq #(.ARESET_CYCLES(AR), .BUSY_TIMEOUT(BT), .LOCK_TIMEOUT(LT)) dut (
    .hb_clk(clk), .hb_rst(rst), .start(start),
    .n_div(n_div), .m_div(m_div), .c0_div(c0_div),
`ifdef PIX_PLL_C1_EN
    .c1_div(c1_div),
`endif
    .busy(busy), .pix_locked(pix_locked),
    .write_param(write_param), .counter_type(counter_type), .counter_param(counter_param),
    .data_in(data_in), .reconfig(reconfig), .pll_areset_in(pll_areset_in),
    .seq_busy(seq_busy), .done(done), .err(err)
  );

  typedef struct {int ct; int cp; int dv;} wr_t;
  wr_t exp_q[$];
  wr_t got[$];

  int checks = 0, errors = 0;
  int cyc = 0, wcount = 0, rcount = 0, dcount = 0, bcnt = 0;
  int stuck_after = 0;
  int ares_run = 0, ares_len = 0, fall_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  int err_seen = 0, err_cyc = 0, err_val = 0;
  int lock_en = 0, lock_delay = 0, lk_cnt = 0, armed = 0;
  logic done_prev = 1'b0;

  function automatic int model_val(int d, int p);
    int dd;
    dd = (d == 0) ? 1 : d;
    case (p)
      0: return (dd + 1) / 2;
      1: return dd / 2;
      2: return (dd == 1) ? 1 : 0;
      default: return dd % 2;
    endcase
  endfunction

  task automatic push_expect(int n, int m, int c0, int c1);
    int ds[4];
    wr_t w;
    ds = '{n, m, c0, c1};
    exp_q.delete();
    for (int c = 0; c < NCNT; c++)
      for (int p = 0; p < 4; p++) begin
        w.ct = (c < 2) ? c : c + 2;
        w.cp = (p < 2) ? p : p + 2;
        w.dv = model_val(ds[c], p);
        exp_q.push_back(w);
      end
  endtask

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // compare process, plus the busy / lock responders for the port
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (write_param) begin
      wcount++;
      last_wr_cyc = cyc;
      bcnt = 3;
      got.push_back('{int'(counter_type), int'(counter_param), int'(data_in)});
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write: got (%0d,%0d,%0d) expected none", counter_type, counter_param, data_in);
      end else begin
        e = exp_q.pop_front();
        if (counter_type != e.ct || counter_param != e.cp || data_in != e.dv) begin
          errors++;
          $display("FAIL write%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", wcount,
                   counter_type, counter_param, data_in, e.ct, e.cp, e.dv);
        end
      end
    end
    if (reconfig) begin
      rcount++;
      bcnt = 3;
    end
    if (stuck_after > 0 && wcount >= stuck_after) busy = 1'b1;
    else begin
      busy = (bcnt > 0);
      if (bcnt > 0) bcnt--;
    end
    if (pll_areset_in) begin
      ares_run++;
      lk_cnt = 0;
      armed = 1;
      pix_locked = 1'b0;
    end else begin
      if (ares_run > 0) begin
        ares_len = ares_run;
        ares_run = 0;
        fall_cyc = cyc;
      end
      if (armed) begin
        if (lock_en != 0 && lk_cnt >= lock_delay) pix_locked = 1'b1;
        lk_cnt++;
      end
    end
    if (done) begin
      dcount++;
      done_cyc = cyc;
    end
    if (err != 2'b00 && err_seen == 0) begin
      err_seen = 1;
      err_cyc = cyc;
      err_val = int'(err);
    end
    checks++;
    if ((int'(write_param) + int'(reconfig) + int'(pll_areset_in)) > 1 ||
        ((write_param || reconfig || pll_areset_in) && !seq_busy) ||
        (done && done_prev) || (done && err != 2'b00)) begin
      errors++;
      $display("FAIL strobes: got wp=%0b rc=%0b ar=%0b sb=%0b dn=%0b err=%0d expected exclusive strobes inside a sequence",
               write_param, reconfig, pll_areset_in, seq_busy, done, err);
    end
    done_prev = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int n, int m, int c0, int c1);
    step();
    n_div = 9'(n); m_div = 9'(m); c0_div = 9'(c0); c1_div = 9'(c1);
    armed = 0; pix_locked = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wcount = 0; rcount = 0; dcount = 0; err_seen = 0; ares_len = 0;
    got.delete();
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (seq_busy && n < 5000) begin
      step();
      n++;
    end
    chk({name, "_idle_in_budget"}, (n < 5000) ? 1 : 0, 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_write_param", write_param, 0);
    chk("rst_reconfig", reconfig, 0);
    chk("rst_areset", pll_areset_in, 0);
    chk("rst_seq_busy", seq_busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_outs", {counter_type, counter_param, data_in}, 0);
    repeat (2) step();
    rst = 1'b0;

    // model pins
    chk("model_hi5", model_val(5, 0), 3);
    chk("model_lo5", model_val(5, 1), 2);
    chk("model_byp1", model_val(1, 2), 1);
    chk("model_hi0", model_val(0, 0), 1);
    chk("model_odd0", model_val(0, 3), 1);

    // basic sequence, plus ignored second start with different values
    lock_en = 1; lock_delay = 5;
    push_expect(1, 8, 5, 1);
    do_start(1, 8, 5, 1);
    repeat (8) step();
    n_div = 9'd7; m_div = 9'd3; c0_div = 9'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("basic");
    chk("basic_writes", wcount, NCNT * 4);
    chk("basic_exp_left", exp_q.size(), 0);
    chk("basic_reconfig", rcount, 1);
    chk("basic_areset_len", ares_len, 16);
    chk("basic_done", dcount, 1);
    chk("basic_lock_latency", done_cyc - fall_cyc, 7);
    chk("basic_err", err, 0);
    if (got.size() >= 12) begin
      chk("basic_w1", got[0].ct * 10000 + got[0].cp * 1000 + got[0].dv, 1);
      chk("basic_w5", got[4].ct * 10000 + got[4].cp * 1000 + got[4].dv, 10004);
      chk("basic_w12", got[11].ct * 10000 + got[11].cp * 1000 + got[11].dv, 45001);
    end else chk("basic_got_size", got.size(), 12);

    // zero divide behaves as one
    push_expect(0, 2, 7, 1);
    do_start(0, 2, 7, 1);
    wait_idle("zero");
    chk("zero_writes", wcount, NCNT * 4);
    if (got.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("zero_n_type", got[i].ct, 0);
        chk("zero_n_data", got[i].dv, (i == 1) ? 0 : 1);
      end
    chk("zero_done", dcount, 1);

    // stuck busy after the 3rd write
    stuck_after = 3;
    push_expect(4, 4, 4, 4);
    do_start(4, 4, 4, 4);
    wait_idle("stuck");
    stuck_after = 0;
    chk("stuck_err", err, 1);
    chk("stuck_writes", wcount, 3);
    chk("stuck_reconfig", rcount, 0);
    chk("stuck_latency", err_cyc - last_wr_cyc, BT + 1);
    chk("stuck_seq_busy", seq_busy, 0);
    repeat (5) step();
    chk("stuck_err_held", err, 1);

    // no lock: timeout exactly LT cycles after areset falls
    lock_en = 0;
    push_expect(2, 3, 4, 5);
    do_start(2, 3, 4, 5);
    chk("err_cleared_on_start", err, 0);
    wait_idle("nolock");
    chk("nolock_err", err, 2);
    chk("nolock_done", dcount, 0);
    chk("nolock_latency", err_cyc - fall_cyc, LT);

    // lock qualifying exactly on the timeout cycle: success wins
    lock_en = 1; lock_delay = LT - 2;
    push_expect(3, 3, 3, 3);
    do_start(3, 3, 3, 3);
    wait_idle("edge_ok");
    chk("edge_ok_done", dcount, 1);
    chk("edge_ok_err", err, 0);
    chk("edge_ok_latency", done_cyc - fall_cyc, LT);

    // lock one cycle too late: timeout
    lock_delay = LT - 1;
    push_expect(3, 3, 3, 3);
    do_start(3, 3, 3, 3);
    wait_idle("edge_late");
    chk("edge_late_done", dcount, 0);
    chk("edge_late_err", err, 2);

    // reset during ARESET
    lock_en = 1; lock_delay = 2;
    push_expect(6, 6, 6, 6);
    do_start(6, 6, 6, 6);
    begin
      int n;
      n = 0;
      while (!pll_areset_in && n < 2000) begin
        step();
        n++;
      end
      chk("rst_mid_reached_areset", pll_areset_in, 1);
    end
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_areset", pll_areset_in, 0);
    chk("rst_mid_seq_busy", seq_busy, 0);
    chk("rst_mid_err", err, 0);
    step();
    rst = 1'b0;

`ifdef PIX_PLL_C1_EN
    // fourth counter
    push_expect(1, 8, 5, 3);
    do_start(1, 8, 5, 3);
    wait_idle("c1");
    chk("c1_writes", wcount, 16);
    if (got.size() >= 16) begin
      chk("c1_w13", got[12].ct * 10000 + got[12].cp * 1000 + got[12].dv, 50002);
      chk("c1_w14", got[13].ct * 10000 + got[13].cp * 1000 + got[13].dv, 51001);
      chk("c1_w15", got[14].ct * 10000 + got[14].cp * 1000 + got[14].dv, 54000);
      chk("c1_w16", got[15].ct * 10000 + got[15].cp * 1000 + got[15].dv, 55001);
    end
`else
    // sequence after mid-run reset completes normally
    lock_delay = 3;
    push_expect(1, 8, 5, 0);
    do_start(1, 8, 5, 0);
    wait_idle("after_rst");
    chk("after_rst_writes", wcount, 12);
    chk("after_rst_done", dcount, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
